// File: rtl/aes_uart_ctrl.sv
// Sequencer between the UART block receiver, the AES core and the byte-wide UART transmitter.
// Optional AES-wait watchdog with sticky timeout output: define AES_CTRL_TIMEOUT_EN.
module aes_uart_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned NUM_BYTES      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [127:0] rx_data,
    input  logic         rekey,
    output logic [127:0] aes_key,
    output logic [127:0] aes_in,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_out,
    input  logic         tx_ready,
    output logic         tx_valid,
    output logic [7:0]   tx_byte,
    output logic         key_loaded,
    output logic         busy,
    output logic         overrun
`ifdef AES_CTRL_TIMEOUT_EN
    ,
    output logic         timeout
`endif
);

    typedef enum logic [2:0] {
        S_KEY_WAIT,
        S_DATA_WAIT,
        S_START,
        S_AES_WAIT,
        S_TX
    } state_e;

    localparam logic [3:0] LAST_CNT = 4'(NUM_BYTES - 1);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] din_q, din_d;
    logic [127:0] res_q, res_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         key_loaded_q, key_loaded_d;
    logic         overrun_q, overrun_d;
    logic         busy_q, busy_d;
    logic         start_q, start_d;
    logic         tx_prev_q, tx_prev_d;
    logic         tx_fire;
`ifdef AES_CTRL_TIMEOUT_EN
    logic [31:0]  wd_q, wd_d;
    logic         timeout_q, timeout_d;
`endif

    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path leaves one unassigned (no latches).
        state_d      = state_q;
        key_d        = key_q;
        din_d        = din_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        key_loaded_d = key_loaded_q;
        overrun_d    = overrun_q;
        tx_fire      = 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
        timeout_d    = timeout_q;
        wd_d         = (state_q == S_AES_WAIT) ? wd_q + 32'd1 : 32'd0;
`endif

        case (state_q)
            S_KEY_WAIT: begin
                if (rx_valid) begin
                    key_d        = rx_data;
                    key_loaded_d = 1'b1;
                    state_d      = S_DATA_WAIT;
                end
            end
            S_DATA_WAIT: begin
                // rekey takes priority; a coincident block is dropped silently
                if (rekey) begin
                    key_loaded_d = 1'b0;
                    state_d      = S_KEY_WAIT;
                end else if (rx_valid) begin
                    din_d   = rx_data;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_AES_WAIT;
            S_AES_WAIT: begin
                if (aes_done) begin
                    res_d   = aes_out;
                    cnt_d   = 4'd0;
                    state_d = S_TX;
                end
`ifdef AES_CTRL_TIMEOUT_EN
                else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DATA_WAIT;
                end
`endif
            end
            S_TX: begin
                // back-to-back pulses are suppressed so the transmitter can drop tx_ready
                if (tx_ready && !tx_prev_q) begin
                    tx_fire = 1'b1;
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) state_d = S_DATA_WAIT;
                end
            end
            default: state_d = S_KEY_WAIT;
        endcase

        if (rx_valid && (state_q inside {S_START, S_AES_WAIT, S_TX})) overrun_d = 1'b1;

        start_d   = (state_q == S_START);
        busy_d    = !(state_d inside {S_KEY_WAIT, S_DATA_WAIT});
        tx_prev_d = tx_fire;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; the 128-bit data registers are reset too, since their values are visible on the ports.
        if (!rst_n) begin
            state_q      <= S_KEY_WAIT;
            key_q        <= '0;
            din_q        <= '0;
            res_q        <= '0;
            cnt_q        <= '0;
            key_loaded_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            tx_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            din_q        <= din_d;
            res_q        <= res_d;
            cnt_q        <= cnt_d;
            key_loaded_q <= key_loaded_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
            tx_prev_q    <= tx_prev_d;
        end
    end

`ifdef AES_CTRL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    assign aes_key    = key_q;
    assign aes_in     = din_q;
    assign aes_start  = start_q;
    assign key_loaded = key_loaded_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign tx_valid   = tx_fire;
    // byte index counts from the MSB end: 15 - cnt is the bitwise inverse of cnt
    assign tx_byte    = res_q[{~cnt_q, 3'b000} +: 8];

endmodule

// File: tb/tb_aes_uart_ctrl.sv
// Directed self-checking bench for aes_uart_ctrl: key load, FIPS-197 stream,
// handshake gaps, overrun, rekey priority and mid-stream reset.
module tb_aes_uart_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_valid;
    logic [127:0] rx_data;
    logic         rekey;
    logic [127:0] aes_key;
    logic [127:0] aes_in;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_out;
    logic         tx_ready;
    logic         tx_valid;
    logic [7:0]   tx_byte;
    logic         key_loaded;
    logic         busy;
    logic         overrun;
`ifdef AES_CTRL_TIMEOUT_EN
    logic         timeout;
`endif

    aes_uart_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rekey     (rekey),
        .aes_key   (aes_key),
        .aes_in    (aes_in),
        .aes_start (aes_start),
        .aes_done  (aes_done),
        .aes_out   (aes_out),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_byte   (tx_byte),
        .key_loaded(key_loaded),
        .busy      (busy),
        .overrun   (overrun)
`ifdef AES_CTRL_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cnt = 0;
    int ready_viol = 0;
    int spacing_viol = 0;
    int last_tx_cyc = -10;
    logic [7:0] tx_q[$];
    int         tx_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: records every transmitted byte and handshake violations.
    always @(negedge clk) begin
        if (aes_start) start_cnt++;
        if (tx_valid === 1'b1) begin
            tx_q.push_back(tx_byte);
            tx_cyc.push_back(cyc);
            if (tx_ready !== 1'b1) ready_viol++;
            if (cyc - last_tx_cyc < 2) spacing_viol++;
            last_tx_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one block on rx for one cycle.
    task automatic send_block(input logic [127:0] blk);
        rx_valid = 1'b1;
        rx_data  = blk;
        tick();
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic pulse_done(input logic [127:0] res);
        aes_done = 1'b1;
        aes_out  = res;
        tick();
        aes_done = 1'b0;
        aes_out  = '0;
    endtask

    localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] PT1  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] CT1  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] KEY2 = 128'hA5A5A5A5_0F0F0F0F_12345678_9ABCDEF0;
    localparam logic [127:0] PT2  = 128'hCAFEF00D_11111111_22222222_33333333;
    localparam logic [127:0] RES2 = 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3;
    localparam logic [127:0] JUNK = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;

    initial begin
        logic [127:0] exp_blk;
        int base;
        int seen;
        int starts0;

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; rekey = 1'b0;
        aes_done = 1'b0; aes_out = '0; tx_ready = 1'b1;
        repeat (3) tick();
        check("rst_key", aes_key, '0);
        check("rst_in", aes_in, '0);
        check("rst_flags", {key_loaded, busy, overrun, aes_start, tx_valid}, '0);
        check("rst_byte", tx_byte, '0);
        rst_n = 1'b1;
        tick();

        // Key load
        send_block(KEY1);
        check("key_val", aes_key, KEY1);
        check("key_loaded", key_loaded, 1'b1);
        check("key_busy", busy, 1'b0);
        tick();
        check("key_no_start", start_cnt, 0);

        // FIPS-197 data block with tx_ready held high
        send_block(PT1);
        check("pt_in", aes_in, PT1);
        check("pt_busy", busy, 1'b1);
        check("start_lat1", aes_start, 1'b0);
        tick();
        check("start_lat2", aes_start, 1'b1);
        tick();
        check("start_one_cycle", aes_start, 1'b0);
        base = tx_q.size();
        pulse_done(CT1);
        check("tx_lat_valid", tx_valid, 1'b1);
        check("tx_lat_byte", tx_byte, 8'h69);
        repeat (40) tick();
        check("run1_count", tx_q.size() - base, 16);
        exp_blk = CT1;
        for (int i = 0; i < 16 && base + i < tx_q.size(); i++)
            check($sformatf("run1_byte%0d", i), tx_q[base + i], exp_blk[127 - 8*i -: 8]);
        if (tx_q.size() - base == 16)
            check("run1_span", tx_cyc[base + 15] - tx_cyc[base], 30);
        check("run1_idle", busy, 1'b0);
        check("run1_starts", start_cnt, 1);

        // Rekey coinciding with a block in S_DATA_WAIT
        rekey = 1'b1;
        send_block(JUNK);
        rekey = 1'b0;
        check("rekey_unloaded", key_loaded, 1'b0);
        check("rekey_no_overrun", overrun, 1'b0);
        check("rekey_in_kept", aes_in, PT1);
        repeat (3) tick();
        check("rekey_no_start", start_cnt, 1);
        send_block(KEY2);
        check("rekey_key", aes_key, KEY2);
        check("rekey_loaded", key_loaded, 1'b1);

        // Overrun during S_AES_WAIT, then a gapped handshake
        tx_ready = 1'b0;
        send_block(PT2);
        tick();
        send_block(JUNK);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_in_kept", aes_in, PT2);
        check("ovr_busy", busy, 1'b1);
        base = tx_q.size();
        pulse_done(RES2);
        repeat (5) tick();
        check("gap_hold", tx_q.size() - base, 0);
        exp_blk = RES2;
        for (int i = 0; i < 16; i++) begin
            tx_ready = 1'b1;
            #1;
            check($sformatf("gap_valid%0d", i), tx_valid, 1'b1);
            check($sformatf("gap_byte%0d", i), tx_byte, exp_blk[127 - 8*i -: 8]);
            tick();
            tx_ready = 1'b0;
            repeat (20) tick();
        end
        check("gap_count", tx_q.size() - base, 16);
        check("gap_idle", busy, 1'b0);
        check("ready_viol", ready_viol, 0);
        check("spacing_viol", spacing_viol, 0);

        // Mid-stream reset after the 5th byte
        tx_ready = 1'b1;
        starts0 = start_cnt;
        send_block(PT1);
        repeat (3) tick();
        check("rst_run_start", start_cnt - starts0, 1);
        base = tx_q.size();
        pulse_done(CT1);
        seen = 0;
        for (int t = 0; t < 40 && seen < 5; t++) begin
            seen = tx_q.size() - base;
            if (seen < 5) tick();
        end
        check("rst_run_5bytes", seen, 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_key", aes_key, '0);
        check("mid_rst_res_byte", tx_byte, '0);
        check("mid_rst_flags", {key_loaded, busy, overrun, aes_start, tx_valid}, '0);
        repeat (40) tick();
        check("mid_rst_no_tx", tx_q.size() - base, 5);
        check("mid_rst_spacing", spacing_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
